// File: rtl/ps2_keystate.sv
// rtl/ps2_keystate.sv - PS/2 set-2 receiver and make/break decoder driving the key matrix state
module ps2_keystate #(
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [0:47] key_state,
    output logic        alpha_state,
    output logic [7:0]  scancode,
    output logic        scancode_valid,
    output logic        frame_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic            clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0]      scancode_q, scancode_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic [2:0]      skip_q, skip_d;
    logic            caps_down_q, caps_down_d;
    logic            alpha_q, alpha_d;
    logic [5:0]      mod_q, mod_d;
    logic [0:47]     keys_q, keys_d;
    logic            fall;
    logic [6:0]      map_res;

    // Returns {mapped, index} for non-modifier keys; modifiers and caps are handled separately.
    function automatic logic [6:0] map_code(input logic ext, input logic [7:0] code);
        map_code = 7'd0;
        if (ext) begin
            if (code == 8'h5A) map_code = {1'b1, 6'd2};
        end else begin
            case (code)
                8'h55: map_code = {1'b1, 6'd0};   8'h29: map_code = {1'b1, 6'd1};
                8'h5A: map_code = {1'b1, 6'd2};
                8'h49: map_code = {1'b1, 6'd8};   8'h4B: map_code = {1'b1, 6'd9};
                8'h44: map_code = {1'b1, 6'd10};  8'h46: map_code = {1'b1, 6'd11};
                8'h1E: map_code = {1'b1, 6'd12};  8'h1B: map_code = {1'b1, 6'd13};
                8'h1D: map_code = {1'b1, 6'd14};  8'h22: map_code = {1'b1, 6'd15};
                8'h41: map_code = {1'b1, 6'd16};  8'h42: map_code = {1'b1, 6'd17};
                8'h43: map_code = {1'b1, 6'd18};  8'h3E: map_code = {1'b1, 6'd19};
                8'h26: map_code = {1'b1, 6'd20};  8'h23: map_code = {1'b1, 6'd21};
                8'h24: map_code = {1'b1, 6'd22};  8'h21: map_code = {1'b1, 6'd23};
                8'h3A: map_code = {1'b1, 6'd24};  8'h3B: map_code = {1'b1, 6'd25};
                8'h3C: map_code = {1'b1, 6'd26};  8'h3D: map_code = {1'b1, 6'd27};
                8'h25: map_code = {1'b1, 6'd28};  8'h2B: map_code = {1'b1, 6'd29};
                8'h2D: map_code = {1'b1, 6'd30};  8'h2A: map_code = {1'b1, 6'd31};
                8'h31: map_code = {1'b1, 6'd32};  8'h33: map_code = {1'b1, 6'd33};
                8'h35: map_code = {1'b1, 6'd34};  8'h36: map_code = {1'b1, 6'd35};
                8'h2E: map_code = {1'b1, 6'd36};  8'h34: map_code = {1'b1, 6'd37};
                8'h2C: map_code = {1'b1, 6'd38};  8'h32: map_code = {1'b1, 6'd39};
                8'h4A: map_code = {1'b1, 6'd40};  8'h4C: map_code = {1'b1, 6'd41};
                8'h4D: map_code = {1'b1, 6'd42};  8'h45: map_code = {1'b1, 6'd43};
                8'h16: map_code = {1'b1, 6'd44};  8'h1C: map_code = {1'b1, 6'd45};
                8'h15: map_code = {1'b1, 6'd46};  8'h1A: map_code = {1'b1, 6'd47};
                default: map_code = 7'd0;
            endcase
        end
    endfunction

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        scancode_d = scancode_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (rx_state_q == RX_IDLE || fall) wd_d = '0;
        else                               wd_d = wd_q + 1'b1;
        case (rx_state_q)
            RX_IDLE: if (fall && !dat_s2_q) begin
                rx_state_d = RX_DATA;
                bit_cnt_d  = 3'd0;
            end
            RX_DATA: if (fall) begin
                shift_d   = {dat_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
            end
            RX_PARITY: if (fall) begin
                par_d      = dat_s2_q;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (fall) begin
                rx_state_d = RX_IDLE;
                if (dat_s2_q && (^{shift_q, par_q})) begin
                    scancode_d = shift_q;
                    valid_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        // A stalled frame is abandoned; the falling-edge case above has priority.
        if (rx_state_q != RX_IDLE && !fall && wd_q == WD_LAST) begin
            rx_state_d = RX_IDLE;
            err_d      = 1'b1;
            wd_d       = '0;
        end
    end

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        skip_d      = skip_q;
        caps_down_d = caps_down_q;
        alpha_d     = alpha_q;
        mod_d       = mod_q;
        keys_d      = keys_q;
        map_res     = map_code(ext_q, scancode_q);
        if (valid_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (scancode_q)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'hE1: skip_d = 3'd7;
                    8'hAA, 8'hFC, 8'hFF: begin
                        keys_d      = '0;
                        mod_d       = '0;
                        caps_down_d = 1'b0;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                    8'h00, 8'hEE, 8'hFA, 8'hFE: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                        case ({ext_q, scancode_q})
                            9'h058: begin
                                if (brk_q) caps_down_d = 1'b0;
                                else if (!caps_down_q) begin
                                    alpha_d     = ~alpha_q;
                                    caps_down_d = 1'b1;
                                end
                            end
                            9'h011: mod_d[0] = ~brk_q;
                            9'h111: mod_d[1] = ~brk_q;
                            9'h012: mod_d[2] = ~brk_q;
                            9'h059: mod_d[3] = ~brk_q;
                            9'h014: mod_d[4] = ~brk_q;
                            9'h114: mod_d[5] = ~brk_q;
                            default: if (map_res[6]) keys_d[map_res[5:0]] = ~brk_q;
                        endcase
                    end
                endcase
            end
        end
        keys_d[3] = 1'b0;
        keys_d[4] = mod_d[0] | mod_d[1];
        keys_d[5] = mod_d[2] | mod_d[3];
        keys_d[6] = mod_d[4] | mod_d[5];
        keys_d[7] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            rx_state_q  <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            wd_q        <= '0;
            scancode_q  <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= '0;
            caps_down_q <= 1'b0;
            alpha_q     <= 1'b1;
            mod_q       <= '0;
            keys_q      <= '0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            clk_prev_q  <= clk_s2_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            scancode_q  <= scancode_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            caps_down_q <= caps_down_d;
            alpha_q     <= alpha_d;
            mod_q       <= mod_d;
            keys_q      <= keys_d;
        end
    end

    assign key_state      = keys_q;
    assign alpha_state    = alpha_q;
    assign scancode       = scancode_q;
    assign scancode_valid = valid_q;
    assign frame_err      = err_q;
endmodule

// File: tb/tb_ps2_keystate.sv
// tb/tb_ps2_keystate.sv - directed and random PS/2 frames checked against a set-based key model
module tb_ps2_keystate;
    localparam int TO   = 200;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [0:47] key_state;
    logic        alpha_state;
    logic [7:0]  scancode;
    logic        scancode_valid;
    logic        frame_err;

    ps2_keystate #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_state(key_state), .alpha_state(alpha_state), .scancode(scancode),
        .scancode_valid(scancode_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    logic        valid_prev = 1'b0;
    logic [0:47] ks_at_valid = '0;
    logic [0:47] ks_after = '0;

    always @(negedge clk) begin
        if (valid_prev) ks_after <= key_state;
        if (scancode_valid) begin
            valid_cnt   <= valid_cnt + 1;
            ks_at_valid <= key_state;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        valid_prev <= scancode_valid;
    end

    // Reference model: the set of currently held physical keys plus prefix state.
    int         keymap[int];
    bit         held[int];
    int         codes_list[$];
    bit         m_ext, m_brk, m_caps, m_alpha;
    int         m_skip;
    logic [7:0] m_sc;

    function automatic void m_reset();
        held.delete();
        m_ext = 0; m_brk = 0; m_caps = 0; m_alpha = 1; m_skip = 0; m_sc = 8'h00;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        int k;
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (b inside {8'hAA, 8'hFC, 8'hFF}) begin
            held.delete(); m_caps = 0; m_ext = 0; m_brk = 0;
        end else if (b inside {8'h00, 8'hEE, 8'hFA, 8'hFE}) begin
            m_ext = 0; m_brk = 0;
        end else begin
            k = (m_ext ? 256 : 0) + int'(b);
            if (k == 'h58) begin
                if (m_brk) m_caps = 0;
                else if (!m_caps) begin
                    m_alpha = !m_alpha;
                    m_caps = 1;
                end
            end else if (keymap.exists(k)) held[k] = !m_brk;
            m_ext = 0; m_brk = 0;
        end
    endfunction

    function automatic logic [0:47] m_keys();
        logic [0:47] r = '0;
        foreach (held[k]) if (held[k]) r[keymap[k]] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input bit v);
        ps2_data = v;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        bit par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(!bad_stop);
        ps2_data = 1'b1;
        wait_cyc(12);
        if (!bad_par && !bad_stop) begin
            m_sc = b;
            m_byte(b);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".keys"}, key_state, m_keys());
        check({tag, ".alpha"}, alpha_state, m_alpha);
        check({tag, ".code"}, scancode, m_sc);
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] b, input bit bp, input bit bs);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(b, bp, bs);
        check({tag, ".vpulse"}, valid_cnt - v0, (bp || bs) ? 0 : 1);
        check({tag, ".epulse"}, err_cnt - e0, (bp || bs) ? 1 : 0);
        check_model(tag);
    endtask

    initial begin
        int idx_codes[40] = '{'h49, 'h4B, 'h44, 'h46, 'h1E, 'h1B, 'h1D, 'h22,
                              'h41, 'h42, 'h43, 'h3E, 'h26, 'h23, 'h24, 'h21,
                              'h3A, 'h3B, 'h3C, 'h3D, 'h25, 'h2B, 'h2D, 'h2A,
                              'h31, 'h33, 'h35, 'h36, 'h2E, 'h34, 'h2C, 'h32,
                              'h4A, 'h4C, 'h4D, 'h45, 'h16, 'h1C, 'h15, 'h1A};
        logic [0:47] ks_snap;
        int v0, e0, r, k;
        for (int i = 0; i < 40; i++) keymap[idx_codes[i]] = i + 8;
        keymap['h55] = 0; keymap['h29] = 1; keymap['h5A] = 2; keymap['h15A] = 2;
        keymap['h11] = 4; keymap['h111] = 4; keymap['h12] = 5; keymap['h59] = 5;
        keymap['h14] = 6; keymap['h114] = 6;
        foreach (keymap[c]) codes_list.push_back(c);
        codes_list.push_back('h58);
        m_reset();

        wait_cyc(4);
        check("rst.keys", key_state, 48'h0);
        check("rst.alpha", alpha_state, 1'b1);
        check("rst.code", scancode, 8'h00);
        check("rst.valid", scancode_valid, 1'b0);
        check("rst.err", frame_err, 1'b0);
        reset_n = 1'b1;
        wait_cyc(4);

        frame_chk("a_make", 8'h1C, 0, 0);
        check("a_make.k45", key_state[45], 1'b1);
        check("a_make.lat_at", ks_at_valid[45], 1'b0);
        check("a_make.lat_next", ks_after[45], 1'b1);
        frame_chk("a_brk0", 8'hF0, 0, 0);
        frame_chk("a_brk1", 8'h1C, 0, 0);
        check("a_brk.zero", key_state, 48'h0);

        frame_chk("ls_make", 8'h12, 0, 0);
        frame_chk("rs_make", 8'h59, 0, 0);
        frame_chk("ls_brk0", 8'hF0, 0, 0);
        frame_chk("ls_brk1", 8'h12, 0, 0);
        check("shift.held", key_state[5], 1'b1);
        frame_chk("rs_brk0", 8'hF0, 0, 0);
        frame_chk("rs_brk1", 8'h59, 0, 0);
        check("shift.rel", key_state[5], 1'b0);

        frame_chk("badpar", 8'h1C, 1, 0);
        frame_chk("badstop", 8'h1C, 0, 1);
        check("bad.k45", key_state[45], 1'b0);

        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        wait_cyc(TO + 20);
        check("tmo.epulse", err_cnt - e0, 1);
        check("tmo.vpulse", valid_cnt - v0, 0);
        frame_chk("after_tmo", 8'h29, 0, 0);
        check("after_tmo.k1", key_state[1], 1'b1);

        frame_chk("caps1", 8'h58, 0, 0);
        check("caps1.alpha", alpha_state, 1'b0);
        frame_chk("caps_rep", 8'h58, 0, 0);
        check("caps_rep.alpha", alpha_state, 1'b0);
        frame_chk("caps_b0", 8'hF0, 0, 0);
        frame_chk("caps_b1", 8'h58, 0, 0);
        frame_chk("caps2", 8'h58, 0, 0);
        check("caps2.alpha", alpha_state, 1'b1);
        frame_chk("ent0", 8'hE0, 0, 0);
        frame_chk("ent1", 8'h5A, 0, 0);
        check("ent.k2", key_state[2], 1'b1);
        ks_snap = key_state;
        frame_chk("pause", 8'hE1, 0, 0);
        frame_chk("pause1", 8'h14, 0, 0);
        frame_chk("pause2", 8'h77, 0, 0);
        frame_chk("pause3", 8'hE1, 0, 0);
        frame_chk("pause4", 8'hF0, 0, 0);
        frame_chk("pause5", 8'h14, 0, 0);
        frame_chk("pause6", 8'hF0, 0, 0);
        frame_chk("pause7", 8'h77, 0, 0);
        check("pause.same", key_state, ks_snap);

        frame_chk("q_make", 8'h15, 0, 0);
        frame_chk("n1_make", 8'h16, 0, 0);
        frame_chk("bat", 8'hAA, 0, 0);
        check("bat.zero", key_state, 48'h0);
        check("bat.alpha", alpha_state, 1'b1);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                k = codes_list[$urandom_range(0, codes_list.size() - 1)];
                if (k >= 256) frame_chk("rnd.e0", 8'hE0, 0, 0);
                if ($urandom_range(0, 2) == 0) frame_chk("rnd.f0", 8'hF0, 0, 0);
                frame_chk("rnd.key", 8'(k), 0, 0);
            end else if (r < 62) frame_chk("rnd.f0s", 8'hF0, 0, 0);
            else if (r < 68) frame_chk("rnd.e0s", 8'hE0, 0, 0);
            else if (r < 72) frame_chk("rnd.bat", 8'hAA, 0, 0);
            else if (r < 74) frame_chk("rnd.e1", 8'hE1, 0, 0);
            else if (r < 79) frame_chk("rnd.bpar", 8'($urandom_range(0, 255)), 1, 0);
            else if (r < 83) frame_chk("rnd.bstop", 8'($urandom_range(0, 255)), 0, 1);
            else frame_chk("rnd.any", 8'($urandom_range(0, 255)), 0, 0);
        end

        frame_chk("pre_rst", 8'h1A, 0, 0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(2);
        reset_n = 1'b0;
        #1;
        check("mrst.keys", key_state, 48'h0);
        check("mrst.alpha", alpha_state, 1'b1);
        check("mrst.code", scancode, 8'h00);
        check("mrst.valid", scancode_valid, 1'b0);
        check("mrst.err", frame_err, 1'b0);
        m_reset();
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(4);
        reset_n = 1'b1;
        wait_cyc(4);
        frame_chk("post_rst", 8'h1C, 0, 0);
        check("post_rst.k45", key_state[45], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
